if_jalr_rs1_sched: RTL and testbench

- Sequences the JALR rs1 (xn) operand fetch for the IFU branch predictor.
- Holds the predictor while a dependency is outstanding, then arbitrates regfile read port 1 between the predictor and the EXU decode stage.
- Captures the read data and returns it to the predictor's target adder with a one-cycle valid pulse.
- Sits between the IFU predictor, the OITF/IR hazard logic and the regfile.

---
 rtl/if_jalr_rs1_sched.sv | 122 ++++++++++++
 tb/tb_if_jalr_rs1_sched.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_jalr_rs1_sched.sv
// JALR rs1 operand sequencer: waits out hazards, arbitrates regfile read port 1 against the EXU,
// and returns the operand to the predictor. Optional write-back bypass: IF_JALR_RS1_SCHED_WB_BYPASS_EN.
module if_jalr_rs1_sched #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned RFIDX_WIDTH = 5,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jalr_req,
  input  logic [RFIDX_WIDTH-1:0] jalr_rs1_idx,
  input  logic                   dep_busy,
  input  logic                   flush,
  input  logic                   exu_rd_req,
  input  logic [RFIDX_WIDTH-1:0] exu_rd_idx,
  output logic                   exu_rd_gnt,
  output logic                   rf_rd_en,
  output logic [RFIDX_WIDTH-1:0] rf_rd_idx,
  input  logic [XLEN-1:0]        rf_rd_data,
`ifdef IF_JALR_RS1_SCHED_WB_BYPASS_EN
  input  logic                   wb_ena,
  input  logic [RFIDX_WIDTH-1:0] wb_idx,
  input  logic [XLEN-1:0]        wb_data,
`endif
  output logic [XLEN-1:0]        bpu_rs1_data,
  output logic                   bpu_rs1_vld,
  output logic                   bpu_wait
);

  localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  typedef enum logic [2:0] {StIdle, StWaitDep, StArb, StRd, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        starve_cnt_q, starve_cnt_d;
  logic [RFIDX_WIDTH-1:0] idx_q, idx_d;
  logic [XLEN-1:0]        data_q, data_d;
  logic                   bypass;
  logic [XLEN-1:0]        byp_data;
  logic                   arb_win;

`ifdef IF_JALR_RS1_SCHED_WB_BYPASS_EN
  assign bypass   = wb_ena && (wb_idx == idx_q) && ((state_q == StWaitDep) || (state_q == StArb));
  assign byp_data = wb_data;
`else
  assign bypass   = 1'b0;
  assign byp_data = '0;
`endif

  // A bypass hit removes the predictor from arbitration that cycle.
  assign arb_win = (state_q == StArb) && !bypass &&
                   (!exu_rd_req || (starve_cnt_q == StarveMax));

  assign exu_rd_gnt   = exu_rd_req && !arb_win;
  assign rf_rd_en     = arb_win || exu_rd_gnt;
  assign rf_rd_idx    = arb_win ? idx_q : exu_rd_idx;
  assign bpu_rs1_data = data_q;
  assign bpu_rs1_vld  = (state_q == StDone);
  assign bpu_wait     = ((state_q == StIdle) && jalr_req) || (state_q == StWaitDep) ||
                        (state_q == StArb) || (state_q == StRd);

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = '0;
    idx_d        = idx_q;
    data_d       = data_q;
    case (state_q)
      StIdle: begin
        if (jalr_req) begin
          idx_d   = jalr_rs1_idx;
          state_d = dep_busy ? StWaitDep : StArb;
        end
      end
      StWaitDep: begin
        if (bypass) begin
          data_d  = byp_data;
          state_d = StDone;
        end else if (!dep_busy) begin
          state_d = StArb;
        end
      end
      StArb: begin
        if (bypass) begin
          data_d  = byp_data;
          state_d = StDone;
        end else if (arb_win) begin
          state_d = StRd;
        end else begin
          starve_cnt_d = (starve_cnt_q == StarveMax) ? starve_cnt_q : starve_cnt_q + CntW'(1);
        end
      end
      StRd: begin
        data_d  = rf_rd_data;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Flush discards any capture; a read already issued this cycle goes unused.
    if (flush) begin
      state_d      = StIdle;
      starve_cnt_d = '0;
      data_d       = data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
      idx_q        <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
    end
  end

endmodule

// File: tb/tb_if_jalr_rs1_sched.sv
// Directed bench for if_jalr_rs1_sched: per-cycle checks of {rf_rd_en, exu_rd_gnt, bpu_wait,
// bpu_rs1_vld} plus read index and returned data at key cycles.
module tb_if_jalr_rs1_sched;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RFW  = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            jalr_req;
  logic [RFW-1:0]  jalr_rs1_idx;
  logic            dep_busy;
  logic            flush;
  logic            exu_rd_req;
  logic [RFW-1:0]  exu_rd_idx;
  logic            exu_rd_gnt;
  logic            rf_rd_en;
  logic [RFW-1:0]  rf_rd_idx;
  logic [XLEN-1:0] rf_rd_data;
  logic [XLEN-1:0] bpu_rs1_data;
  logic            bpu_rs1_vld;
  logic            bpu_wait;
`ifdef IF_JALR_RS1_SCHED_WB_BYPASS_EN
  logic            wb_ena;
  logic [RFW-1:0]  wb_idx;
  logic [XLEN-1:0] wb_data;
`endif

  logic [XLEN-1:0] rf [32];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Regfile read port: data one cycle after the enable.
  always @(posedge clk) if (rf_rd_en) rf_rd_data <= rf[rf_rd_idx];

  if_jalr_rs1_sched #(.XLEN(XLEN), .RFIDX_WIDTH(RFW), .STARVE_MAX(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .jalr_req     (jalr_req),
    .jalr_rs1_idx (jalr_rs1_idx),
    .dep_busy     (dep_busy),
    .flush        (flush),
    .exu_rd_req   (exu_rd_req),
    .exu_rd_idx   (exu_rd_idx),
    .exu_rd_gnt   (exu_rd_gnt),
    .rf_rd_en     (rf_rd_en),
    .rf_rd_idx    (rf_rd_idx),
    .rf_rd_data   (rf_rd_data),
`ifdef IF_JALR_RS1_SCHED_WB_BYPASS_EN
    .wb_ena       (wb_ena),
    .wb_idx       (wb_idx),
    .wb_data      (wb_data),
`endif
    .bpu_rs1_data (bpu_rs1_data),
    .bpu_rs1_vld  (bpu_rs1_vld),
    .bpu_wait     (bpu_wait)
  );

  task automatic quiet_inputs();
    rst          = 1'b0;
    jalr_req     = 1'b0;
    jalr_rs1_idx = '0;
    dep_busy     = 1'b0;
    flush        = 1'b0;
    exu_rd_req   = 1'b0;
    exu_rd_idx   = '0;
`ifdef IF_JALR_RS1_SCHED_WB_BYPASS_EN
    wb_ena       = 1'b0;
    wb_idx       = '0;
    wb_data      = '0;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    quiet_inputs();
    do_reset();
    #1;
    checks++;
    if ({rf_rd_en, exu_rd_gnt, bpu_wait, bpu_rs1_vld} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=0000", {rf_rd_en, exu_rd_gnt, bpu_wait, bpu_rs1_vld});
    end
    checks++;
    if (bpu_rs1_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got=%h want=00000000", bpu_rs1_data);
    end
    @(negedge clk);
  endtask

  task automatic test_uncontended();
    logic [3:0] exp [5] = '{4'b0010, 4'b1010, 4'b0010, 4'b0001, 4'b0000};
    rf[5] = 32'h8000_0100;
    for (int c = 0; c < 5; c++) begin
      jalr_req     = (c == 0);
      jalr_rs1_idx = 5'd5;
      #1;
      checks++;
      if ({rf_rd_en, exu_rd_gnt, bpu_wait, bpu_rs1_vld} !== exp[c]) begin
        failures++;
        $display("FAIL uncont_c%0d got=%b want=%b", c,
                 {rf_rd_en, exu_rd_gnt, bpu_wait, bpu_rs1_vld}, exp[c]);
      end
      if (c == 1) begin
        checks++;
        if (rf_rd_idx !== 5'd5) begin
          failures++;
          $display("FAIL uncont_idx got=%0d want=5", rf_rd_idx);
        end
      end
      if (c == 3) begin
        checks++;
        if (bpu_rs1_data !== 32'h8000_0100) begin
          failures++;
          $display("FAIL uncont_data got=%h want=80000100", bpu_rs1_data);
        end
      end
      @(negedge clk);
    end
    quiet_inputs();
  endtask

  task automatic test_dependency();
    logic [3:0] exp [8] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010,
                            4'b0010, 4'b1010, 4'b0010, 4'b0001};
    rf[7] = 32'hCAFE_0007;
    for (int c = 0; c < 8; c++) begin
      jalr_req     = (c == 0);
      jalr_rs1_idx = 5'd7;
      dep_busy     = (c < 4);
      #1;
      checks++;
      if ({rf_rd_en, exu_rd_gnt, bpu_wait, bpu_rs1_vld} !== exp[c]) begin
        failures++;
        $display("FAIL dep_c%0d got=%b want=%b", c,
                 {rf_rd_en, exu_rd_gnt, bpu_wait, bpu_rs1_vld}, exp[c]);
      end
      if (c == 7) begin
        checks++;
        if (bpu_rs1_data !== 32'hCAFE_0007) begin
          failures++;
          $display("FAIL dep_data got=%h want=cafe0007", bpu_rs1_data);
        end
      end
      @(negedge clk);
    end
    quiet_inputs();
  endtask

  task automatic test_starvation();
    logic [3:0] exp [8] = '{4'b1110, 4'b1110, 4'b1110, 4'b1110,
                            4'b1110, 4'b1010, 4'b1110, 4'b1101};
    logic [RFW-1:0] exp_idx;
    rf[10] = 32'h0000_A0A0;
    rf[2]  = 32'h2222_2222;
    for (int c = 0; c < 8; c++) begin
      jalr_req     = (c == 0);
      jalr_rs1_idx = 5'd10;
      exu_rd_req   = 1'b1;
      exu_rd_idx   = 5'd2;
      exp_idx      = (c == 5) ? 5'd10 : 5'd2;
      #1;
      checks++;
      if ({rf_rd_en, exu_rd_gnt, bpu_wait, bpu_rs1_vld} !== exp[c] || rf_rd_idx !== exp_idx) begin
        failures++;
        $display("FAIL starve_c%0d got=%b/%0d want=%b/%0d", c,
                 {rf_rd_en, exu_rd_gnt, bpu_wait, bpu_rs1_vld}, rf_rd_idx, exp[c], exp_idx);
      end
      if (c == 7) begin
        checks++;
        if (bpu_rs1_data !== 32'h0000_A0A0) begin
          failures++;
          $display("FAIL starve_data got=%h want=0000a0a0", bpu_rs1_data);
        end
      end
      @(negedge clk);
    end
    quiet_inputs();
  endtask

  task automatic test_flush_rd();
    logic [3:0] exp [5] = '{4'b0010, 4'b1010, 4'b0010, 4'b0000, 4'b0000};
    do_reset();
    rf[12] = 32'h5555_5555;
    for (int c = 0; c < 5; c++) begin
      jalr_req     = (c == 0);
      jalr_rs1_idx = 5'd12;
      flush        = (c == 2);
      #1;
      checks++;
      if ({rf_rd_en, exu_rd_gnt, bpu_wait, bpu_rs1_vld} !== exp[c]) begin
        failures++;
        $display("FAIL flush_c%0d got=%b want=%b", c,
                 {rf_rd_en, exu_rd_gnt, bpu_wait, bpu_rs1_vld}, exp[c]);
      end
      if (c >= 3) begin
        checks++;
        if (bpu_rs1_data !== 32'h0) begin
          failures++;
          $display("FAIL flush_data got=%h want=00000000", bpu_rs1_data);
        end
      end
      @(negedge clk);
    end
    quiet_inputs();
  endtask

  task automatic test_reset_mid_wait();
    logic [3:0] exp [8] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000,
                            4'b0010, 4'b1010, 4'b0010, 4'b0001};
    for (int c = 0; c < 8; c++) begin
      jalr_req     = (c == 0) || (c == 4);
      jalr_rs1_idx = (c < 4) ? 5'd7 : 5'd5;
      dep_busy     = (c < 3);
      rst          = (c == 2);
      #1;
      checks++;
      if ({rf_rd_en, exu_rd_gnt, bpu_wait, bpu_rs1_vld} !== exp[c]) begin
        failures++;
        $display("FAIL rstmid_c%0d got=%b want=%b", c,
                 {rf_rd_en, exu_rd_gnt, bpu_wait, bpu_rs1_vld}, exp[c]);
      end
      if (c == 3) begin
        checks++;
        if (bpu_rs1_data !== 32'h0) begin
          failures++;
          $display("FAIL rstmid_data0 got=%h want=00000000", bpu_rs1_data);
        end
      end
      if (c == 5) begin
        checks++;
        if (rf_rd_idx !== 5'd5) begin
          failures++;
          $display("FAIL rstmid_idx got=%0d want=5", rf_rd_idx);
        end
      end
      if (c == 7) begin
        checks++;
        if (bpu_rs1_data !== 32'h8000_0100) begin
          failures++;
          $display("FAIL rstmid_data got=%h want=80000100", bpu_rs1_data);
        end
      end
      @(negedge clk);
    end
    quiet_inputs();
  endtask

  // A request held through DONE is only taken in the following IDLE cycle.
  task automatic test_back_to_back();
    logic [3:0] exp [6] = '{4'b0010, 4'b1010, 4'b0010, 4'b0001, 4'b0010, 4'b1010};
    rf[7] = 32'h7777_0007;
    for (int c = 0; c < 6; c++) begin
      jalr_req     = (c == 0) || (c == 3) || (c == 4);
      jalr_rs1_idx = (c < 3) ? 5'd5 : 5'd7;
      #1;
      checks++;
      if ({rf_rd_en, exu_rd_gnt, bpu_wait, bpu_rs1_vld} !== exp[c]) begin
        failures++;
        $display("FAIL b2b_c%0d got=%b want=%b", c,
                 {rf_rd_en, exu_rd_gnt, bpu_wait, bpu_rs1_vld}, exp[c]);
      end
      if (c == 5) begin
        checks++;
        if (rf_rd_idx !== 5'd7) begin
          failures++;
          $display("FAIL b2b_idx got=%0d want=7", rf_rd_idx);
        end
      end
      @(negedge clk);
    end
    quiet_inputs();
    repeat (3) @(negedge clk);
  endtask

`ifdef IF_JALR_RS1_SCHED_WB_BYPASS_EN
  task automatic test_bypass();
    logic [3:0] exp [4] = '{4'b0010, 4'b0010, 4'b0001, 4'b0000};
    for (int c = 0; c < 4; c++) begin
      jalr_req     = (c == 0);
      jalr_rs1_idx = 5'd9;
      dep_busy     = (c < 2);
      wb_ena       = (c == 1);
      wb_idx       = 5'd9;
      wb_data      = 32'h0000_1234;
      #1;
      checks++;
      if ({rf_rd_en, exu_rd_gnt, bpu_wait, bpu_rs1_vld} !== exp[c]) begin
        failures++;
        $display("FAIL bypass_c%0d got=%b want=%b", c,
                 {rf_rd_en, exu_rd_gnt, bpu_wait, bpu_rs1_vld}, exp[c]);
      end
      if (c == 2) begin
        checks++;
        if (bpu_rs1_data !== 32'h0000_1234) begin
          failures++;
          $display("FAIL bypass_data got=%h want=00001234", bpu_rs1_data);
        end
      end
      @(negedge clk);
    end
    quiet_inputs();
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf_rd_data = '0;
    quiet_inputs();
    @(negedge clk);
    test_reset();
    test_flush_rd();
    test_uncontended();
    test_dependency();
    test_starvation();
    test_reset_mid_wait();
    test_back_to_back();
`ifdef IF_JALR_RS1_SCHED_WB_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
